axis_parity_checker: RTL and testbench

//  Receive side of the byte-stream parity scheme: accepts AXI-Stream packets whose final beat
//  (tlast) carries a parity byte (bitwise XOR of all preceding payload bytes), strips that byte,
//  re-emits the payload with tlast moved to the last payload byte, and flags parity errors.

---
 rtl/axis_parity_pkg.sv | 15 +
 rtl/axis_out_reg.sv | 53 +++++
 rtl/axis_parity_checker.sv | 129 ++++++++++++
 tb/tb_axis_parity_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_parity_pkg.sv
// Shared definitions for the byte-stream parity scheme (generator and checker).
package axis_parity_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT  = 16;

  typedef logic [DATA_W_DEFAULT-1:0] byte_t;

  // Expected parity byte for a payload whose running XOR is acc.
  // odd = 1 selects inverted (odd) parity.
  function automatic byte_t parity_f(input byte_t acc, input logic odd);
    return acc ^ {DATA_W_DEFAULT{odd}};
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream register slice carrying data/last/user.
// Holds its beat stable while the consumer stalls; the loader guarantees
// i_load only when the slice is empty or draining in the same cycle.
module axis_out_reg
  import axis_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_user,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_user
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_user;

  // Load a new beat, otherwise clear the slot once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_user  <= 1'b0;
    end else if (i_load) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or block order.
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_user  <= i_user;
    end else if (i_ready && r_valid) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_user  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_user  = r_user;

endmodule

// File: rtl/axis_parity_checker.sv
// Receive side of the byte-stream parity scheme: strips the trailing parity
// byte, moves tlast onto the last payload byte and flags parity errors.
// A payload byte waits in the hold register until the next beat reveals
// whether it was the last one of its packet.
module axis_parity_checker
  import axis_parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              in_clock,
  input  logic              in_reset_n,
  input  logic              axis_s_tvalid,
  input  logic [DATA_W-1:0] axis_s_tdata,
  output logic              axis_s_tready,
  input  logic              axis_s_tlast,
  output logic              axis_m_tvalid,
  output logic [DATA_W-1:0] axis_m_tdata,
  input  logic              axis_m_tready,
  output logic              axis_m_tlast,
  output logic              axis_m_tuser,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_h_valid;
  logic [DATA_W-1:0] r_h_data;
  logic [DATA_W-1:0] r_acc;
  logic              r_pkt_ok;
  logic              r_pkt_err;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_s_tready;
  logic              w_accept;
  logic              w_payload_beat;
  logic              w_parity_beat;
  logic              w_o_valid;
  logic              w_o_load;
  logic [DATA_W-1:0] w_exp;
  logic              w_err;
  logic              w_pkt_bad;

  // NOTE: ready is forced low during reset because the empty hold register
  // would otherwise advertise space while the block is held in reset.
  assign w_s_tready     = in_reset_n & (~r_h_valid | ~w_o_valid | axis_m_tready);
  assign w_accept       = axis_s_tvalid & w_s_tready;
  assign w_payload_beat = w_accept & ~axis_s_tlast;
  assign w_parity_beat  = w_accept & axis_s_tlast;

  assign w_exp     = parity_f(r_acc, PARITY_ODD);
  assign w_err     = (axis_s_tdata != w_exp);
  // A parity beat with nothing held is a zero-payload packet: always an error.
  assign w_pkt_bad = w_err | ~r_h_valid;

  // Any accepted beat pushes a held byte onward; tlast on the incoming beat
  // tells us the held byte was the final payload byte.
  assign w_o_load = w_accept & r_h_valid;

  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (in_clock),
    .rst_n   (in_reset_n),
    .i_load  (w_o_load),
    .i_data  (r_h_data),
    .i_last  (axis_s_tlast),
    .i_user  (axis_s_tlast & w_err),
    .i_ready (axis_m_tready),
    .o_valid (w_o_valid),
    .o_data  (axis_m_tdata),
    .o_last  (axis_m_tlast),
    .o_user  (axis_m_tuser)
  );

  // Hold register: captures payload bytes, empties on the parity beat.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_h_valid <= 1'b0;
      r_h_data  <= '0;
    end else if (w_payload_beat) begin
      r_h_valid <= 1'b1;
      r_h_data  <= axis_s_tdata;
    end else if (w_parity_beat) begin
      r_h_valid <= 1'b0;
    end
  end

  // Running XOR of the payload; restarts at zero after every parity beat.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_acc <= '0;
    end else if (w_payload_beat) begin
      r_acc <= r_acc ^ axis_s_tdata;
    end else if (w_parity_beat) begin
      r_acc <= '0;
    end
  end

  // One-cycle packet status pulses, raised the cycle after the parity beat.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_pkt_ok  <= 1'b0;
      r_pkt_err <= 1'b0;
    end else begin
      r_pkt_ok  <= w_parity_beat & ~w_pkt_bad;
      r_pkt_err <= w_parity_beat & w_pkt_bad;
    end
  end

  // Saturating error counter, updated together with the pkt_err pulse.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_err_count <= '0;
    end else if (w_parity_beat && w_pkt_bad && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign axis_s_tready = w_s_tready;
  assign axis_m_tvalid = w_o_valid;
  assign pkt_ok        = r_pkt_ok;
  assign pkt_err       = r_pkt_err;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_axis_parity_checker.sv
// Self-checking bench for axis_parity_checker: directed packets plus a
// randomized backpressure run, scored against queues of expected beats and
// expected status pulses filled as stimulus is driven.
module tb_axis_parity_checker;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst_n;

  // Main DUT (even parity)
  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic        s_tready;
  logic        s_tlast;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        pkt_ok;
  logic        pkt_err;
  logic [15:0] err_count;

  // Second DUT (odd parity)
  logic        odd_s_tvalid;
  logic [7:0]  odd_s_tdata;
  logic        odd_s_tready;
  logic        odd_s_tlast;
  logic        odd_m_tvalid;
  logic [7:0]  odd_m_tdata;
  logic        odd_m_tready;
  logic        odd_m_tlast;
  logic        odd_m_tuser;
  logic        odd_pkt_ok;
  logic        odd_pkt_err;
  logic [15:0] odd_err_count;

  logic        rand_mode;
  logic        rand_rdy;
  logic        fix_rdy;

  beat_t       exp_q[$];
  logic        st_q[$];
  int          exp_errs;
  int          total;
  int          bad;

  assign m_tready = rand_mode ? rand_rdy : fix_rdy;

  axis_parity_checker #(.DATA_W(8), .CNT_W(16), .PARITY_ODD(1'b0)) dut (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .axis_s_tvalid (s_tvalid),
    .axis_s_tdata  (s_tdata),
    .axis_s_tready (s_tready),
    .axis_s_tlast  (s_tlast),
    .axis_m_tvalid (m_tvalid),
    .axis_m_tdata  (m_tdata),
    .axis_m_tready (m_tready),
    .axis_m_tlast  (m_tlast),
    .axis_m_tuser  (m_tuser),
    .pkt_ok        (pkt_ok),
    .pkt_err       (pkt_err),
    .err_count     (err_count)
  );

  axis_parity_checker #(.DATA_W(8), .CNT_W(16), .PARITY_ODD(1'b1)) dut_odd (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .axis_s_tvalid (odd_s_tvalid),
    .axis_s_tdata  (odd_s_tdata),
    .axis_s_tready (odd_s_tready),
    .axis_s_tlast  (odd_s_tlast),
    .axis_m_tvalid (odd_m_tvalid),
    .axis_m_tdata  (odd_m_tdata),
    .axis_m_tready (odd_m_tready),
    .axis_m_tlast  (odd_m_tlast),
    .axis_m_tuser  (odd_m_tuser),
    .pkt_ok        (odd_pkt_ok),
    .pkt_err       (odd_pkt_err),
    .err_count     (odd_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random downstream ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rand_rdy = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scores beats, status pulses and stability under stall.
  task automatic monitor();
    logic  stall_prev;
    beat_t held;
    beat_t e;
    logic  se;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid_held", 32'(m_tvalid), 32'(1));
          check("stall_beat_held", 32'({m_tdata, m_tlast, m_tuser}), 32'(held));
        end
        if (m_tvalid && m_tready) begin
          check("beat_expected", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m_beat", 32'({m_tdata, m_tlast, m_tuser}), 32'(e));
          end
        end
        if (pkt_ok || pkt_err) begin
          check("status_expected", 32'(st_q.size() > 0), 32'(1));
          if (st_q.size() > 0) begin
            se = st_q.pop_front();
            check("pkt_ok", 32'(pkt_ok), 32'(!se));
            check("pkt_err", 32'(pkt_err), 32'(se));
          end
        end
        stall_prev = m_tvalid && !m_tready;
        held       = {m_tdata, m_tlast, m_tuser};
      end
    end
  endtask

  // Offer one beat; returns just after the rising edge that accepted it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    logic hs;
    int   n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("s_handshake_timeout", 32'(hs), 32'(1));
  endtask

  // Send a packet and record what the checker must produce for it.
  task automatic send_pkt(input bq_t pl, input logic [7:0] par, input bit hold);
    logic [7:0] x;
    logic       err;
    beat_t      b;
    x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    err = (par != x) || (pl.size() == 0);
    foreach (pl[i]) begin
      b.data = pl[i];
      b.last = (i == pl.size() - 1);
      b.user = b.last & err;
      exp_q.push_back(b);
    end
    st_q.push_back(err);
    if (err) exp_errs++;
    foreach (pl[i]) send_beat(pl[i], 1'b0);
    send_beat(par, 1'b1);
    if (!hold) s_tvalid = 1'b0;
  endtask

  // Wait for all expected output to appear, then confirm nothing is left.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drain_beats_left", 32'(exp_q.size()), 32'(0));
    check("drain_status_left", 32'(st_q.size()), 32'(0));
    exp_q.delete();
    st_q.delete();
  endtask

  initial begin
    bq_t        pl;
    int         len;
    logic [7:0] x;
    logic [7:0] par;

    total    = 0;
    bad      = 0;
    exp_errs = 0;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    rand_mode = 1'b0;
    fix_rdy   = 1'b1;
    odd_s_tvalid = 1'b0;
    odd_s_tdata  = 8'h00;
    odd_s_tlast  = 1'b0;
    odd_m_tready = 1'b1;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'(0));
    check("rst_m_tlast", 32'(m_tlast), 32'(0));
    check("rst_m_tuser", 32'(m_tuser), 32'(0));
    check("rst_pkt_ok", 32'(pkt_ok), 32'(0));
    check("rst_pkt_err", 32'(pkt_err), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    check("rst_s_tready", 32'(s_tready), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", 32'(s_tready), 32'(1));

    // 1. Good packet
    pl.delete();
    pl.push_back(8'h12);
    pl.push_back(8'h34);
    pl.push_back(8'h56);
    send_pkt(pl, 8'h70, 1'b0);
    drain();
    check("t1_err_count", 32'(err_count), 32'(exp_errs));

    // 2. Same payload, wrong parity
    send_pkt(pl, 8'h71, 1'b0);
    drain();
    check("t2_err_count", 32'(err_count), 32'(exp_errs));

    // 3. Zero-payload packet
    pl.delete();
    send_pkt(pl, 8'h00, 1'b0);
    drain();
    check("t3_err_count", 32'(err_count), 32'(exp_errs));

    // 5. Back-to-back packets with tvalid held high
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'hAA);
    send_pkt(pl, 8'h00, 1'b1);
    pl.delete();
    pl.push_back(8'h01);
    pl.push_back(8'h01);
    send_pkt(pl, 8'h00, 1'b0);
    drain();
    check("t5_err_count", 32'(err_count), 32'(exp_errs));

    // 4. Random packets under random backpressure
    rand_mode = 1'b1;
    for (int p = 0; p < 400; p++) begin
      len = $urandom_range(1, 64);
      pl.delete();
      x = 8'h00;
      for (int i = 0; i < len; i++) begin
        pl.push_back(8'($urandom));
        x ^= pl[i];
      end
      par = x;
      if ($urandom_range(0, 3) == 0) par = x ^ 8'($urandom_range(1, 255));
      send_pkt(pl, par, 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_tvalid = 1'b0;
    drain();
    rand_mode = 1'b0;
    check("t4_err_count", 32'(err_count), 32'(exp_errs));

    // 6. Reset in the middle of a packet, downstream stalled
    fix_rdy = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 32'(m_tvalid), 32'(0));
    check("mid_rst_s_tready", 32'(s_tready), 32'(0));
    check("mid_rst_err_count", 32'(err_count), 32'(0));
    exp_errs = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    fix_rdy = 1'b1;
    @(posedge clk);
    #1;
    pl.delete();
    pl.push_back(8'h33);
    pl.push_back(8'h44);
    send_pkt(pl, 8'h77, 1'b0);
    drain();
    check("t6_err_count", 32'(err_count), 32'(exp_errs));

    // 6b. Odd parity instance: payload 0x0F, parity 0xF0
    odd_s_tvalid = 1'b1;
    odd_s_tdata  = 8'h0F;
    odd_s_tlast  = 1'b0;
    @(negedge clk);
    check("odd_s_tready_payload", 32'(odd_s_tready), 32'(1));
    @(posedge clk);
    #1;
    odd_s_tdata = 8'hF0;
    odd_s_tlast = 1'b1;
    @(negedge clk);
    check("odd_s_tready_parity", 32'(odd_s_tready), 32'(1));
    @(posedge clk);
    #1;
    odd_s_tvalid = 1'b0;
    @(negedge clk);
    check("odd_m_beat", 32'({odd_m_tvalid, odd_m_tdata, odd_m_tlast, odd_m_tuser}),
          32'({1'b1, 8'h0F, 1'b1, 1'b0}));
    check("odd_pkt_ok", 32'(odd_pkt_ok), 32'(1));
    check("odd_pkt_err", 32'(odd_pkt_err), 32'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("odd_m_tvalid_after", 32'(odd_m_tvalid), 32'(0));
    check("odd_pkt_ok_pulse", 32'(odd_pkt_ok), 32'(0));
    check("odd_err_count", 32'(odd_err_count), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
